// File: rtl/ysyx_25030085_trap_seq.sv
// Trap sequencer: drives the CSR file's single port to enter a trap (ecall)
// or return from one (mret), then issues a one-cycle PC redirect.
// Optional feature macro: YSYX_25030085_TRAP_VECTORED_EN
//   defined   -> vectored mtvec mode for interrupt causes
//   undefined -> direct mode only; mtvec[1:0] ignored
// csr_addr/csr_wen/csr_wdata are decoded from the state register and may depend
// combinationally on csr_rdata (read-modify-write of mstatus in one cycle).
module ysyx_25030085_trap_seq #(
    parameter int unsigned XLEN     = 32,
    parameter logic [11:0] MTVEC_A  = 12'h305,
    parameter logic [11:0] MEPC_A   = 12'h341,
    parameter logic [11:0] MCAUSE_A = 12'h342,
    parameter logic [11:0] MSTAT_A  = 12'h300
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_own,
    output logic [11:0]     csr_addr,
    output logic [1:0]      csr_wen,
    output logic [XLEN-1:0] csr_wdata,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned WEN_W     = 2;
    localparam logic [WEN_W-1:0] WEN_NONE  = 2'b00;
    localparam logic [WEN_W-1:0] WEN_WRITE = 2'b01;

    // mstatus field positions
    localparam int unsigned MIE_B  = 3;
    localparam int unsigned MPIE_B = 7;
    localparam int unsigned MPP_LO = 11;
    localparam int unsigned MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STAT,
        S_T_VEC,
        S_R_STAT,
        S_R_EPC,
        S_REDIR
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] vec_base;

    assign vec_base = {csr_rdata[XLEN-1:2], 2'b00};

    // State, latched trap context and redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            redir_q <= redir_d;
        end
    end

    // Next-state, CSR port drive and redirect target computation
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        redir_d        = redir_q;
        csr_addr       = '0;
        csr_wen        = WEN_NONE;
        csr_wdata      = '0;
        redirect_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trap_req) begin
                    pc_d    = trap_pc;
                    cause_d = trap_cause;
                    state_d = S_T_EPC;
                end else if (mret_req) begin
                    state_d = S_R_STAT;
                end
            end
            S_T_EPC: begin
                csr_addr  = MEPC_A;
                csr_wen   = WEN_WRITE;
                csr_wdata = pc_q;
                state_d   = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr  = MCAUSE_A;
                csr_wen   = WEN_WRITE;
                csr_wdata = cause_q;
                state_d   = S_T_STAT;
            end
            S_T_STAT: begin
                csr_addr                = MSTAT_A;
                csr_wen                 = WEN_WRITE;
                csr_wdata               = csr_rdata;
                csr_wdata[MPIE_B]       = csr_rdata[MIE_B];
                csr_wdata[MIE_B]        = 1'b0;
                csr_wdata[MPP_HI:MPP_LO] = 2'b11;
                state_d                 = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr = MTVEC_A;
                redir_d  = vec_base;
`ifdef YSYX_25030085_TRAP_VECTORED_EN
                if (csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1]) begin
                    redir_d = vec_base + XLEN'({cause_q[XLEN-2:0], 2'b00});
                end
`endif
                state_d  = S_REDIR;
            end
            S_R_STAT: begin
                csr_addr                = MSTAT_A;
                csr_wen                 = WEN_WRITE;
                csr_wdata               = csr_rdata;
                csr_wdata[MIE_B]        = csr_rdata[MPIE_B];
                csr_wdata[MPIE_B]       = 1'b1;
                csr_wdata[MPP_HI:MPP_LO] = 2'b00;
                state_d                 = S_R_EPC;
            end
            S_R_EPC: begin
                csr_addr = MEPC_A;
                redir_d  = vec_base;
                state_d  = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset landing mid-sequence must not commit another write or redirect
        if (rst) begin
            csr_addr       = '0;
            csr_wen        = WEN_NONE;
            csr_wdata      = '0;
            redirect_valid = 1'b0;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign csr_own     = busy;
    assign redirect_pc = redir_q;

endmodule

// File: tb/tb_ysyx_25030085_trap_seq.sv
// Bench for ysyx_25030085_trap_seq: a small CSR file model answers the port,
// directed vectors cover trap/mret, then hand sequences cover reset and busy corners.
module tb_ysyx_25030085_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, mret_req;
    logic [31:0] trap_pc, trap_cause, csr_rdata;
    logic        csr_own;
    logic [11:0] csr_addr;
    logic [1:0]  csr_wen;
    logic [31:0] csr_wdata;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_25030085_trap_seq dut (
        .clk            (clk),
        .rst            (rst),
        .trap_req       (trap_req),
        .mret_req       (mret_req),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .csr_rdata      (csr_rdata),
        .csr_own        (csr_own),
        .csr_addr       (csr_addr),
        .csr_wen        (csr_wen),
        .csr_wdata      (csr_wdata),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- CSR file model ----------------
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mstat;
    logic        ld;
    logic [31:0] ld_mtvec, ld_mepc, ld_mcause, ld_mstat;
    int          wr_cnt;
    logic [11:0] wr_addr [8];
    int          wr_cyc  [8];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            12'h300: csr_rdata = m_mstat;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (ld) begin
            m_mtvec  <= ld_mtvec;
            m_mepc   <= ld_mepc;
            m_mcause <= ld_mcause;
            m_mstat  <= ld_mstat;
            wr_cnt   <= 0;
        end else if (csr_own && csr_wen == 2'b01) begin
            case (csr_addr)
                12'h305: m_mtvec  <= csr_wdata;
                12'h341: m_mepc   <= csr_wdata;
                12'h342: m_mcause <= csr_wdata;
                12'h300: m_mstat  <= csr_wdata;
                default: ;
            endcase
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] <= csr_addr;
                wr_cyc[wr_cnt]  <= cyc;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] tv, input logic [31:0] ep,
                           input logic [31:0] mc, input logic [31:0] ms);
        ld_mtvec = tv; ld_mepc = ep; ld_mcause = mc; ld_mstat = ms;
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        trap;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] mtvec;
        logic [31:0] mepc0;
        logic [31:0] mcause0;
        logic [31:0] mstat0;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mstat;
        logic [31:0] exp_redir;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    logic [31:0] vec_redir;
    int          lat, pulses;

    initial begin
`ifdef YSYX_25030085_TRAP_VECTORED_EN
        vec_redir = 32'h8000101C;
`else
        vec_redir = 32'h80001000;
`endif
        //          name        trap  mret  pc            cause         mtvec         mepc0         mcause0       mstat0        exp_mepc      exp_mcause    exp_mstat     exp_redir     lat wr
        vecs[0] = '{"trap",     1'b1, 1'b0, 32'h80000100, 32'h0000000B, 32'h80001000, 32'h0,        32'h0,        32'h00000008, 32'h80000100, 32'h0000000B, 32'h00001880, 32'h80001000, 5, 3};
        vecs[1] = '{"mret",     1'b0, 1'b1, 32'h0,        32'h0,        32'h80001000, 32'h80000104, 32'h0000DEAD, 32'h00001880, 32'h80000104, 32'h0000DEAD, 32'h00000088, 32'h80000104, 3, 1};
        vecs[2] = '{"both",     1'b1, 1'b1, 32'h80000100, 32'h0000000B, 32'h80001000, 32'h0,        32'h0,        32'h00000008, 32'h80000100, 32'h0000000B, 32'h00001880, 32'h80001000, 5, 3};
        vecs[3] = '{"vectored", 1'b1, 1'b0, 32'h80000200, 32'h80000007, 32'h80001001, 32'h0,        32'h0,        32'h00000000, 32'h80000200, 32'h80000007, 32'h00001800, vec_redir,    5, 3};
        vecs[4] = '{"trap_ones",1'b1, 1'b0, 32'h00000004, 32'h00000002, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000004, 32'h00000002, 32'hFFFFFFF7, 32'h00000000, 5, 3};
        vecs[5] = '{"mret_mie", 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h00000203, 32'h00000011, 32'h00001808, 32'h00000203, 32'h00000011, 32'h00000080, 32'h00000200, 3, 1};

        rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
        trap_pc = '0; trap_cause = '0; ld = 1'b0;
        ld_mtvec = '0; ld_mepc = '0; ld_mcause = '0; ld_mstat = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",     32'(busy),           32'h0);
        chk("rst_own",      32'(csr_own),        32'h0);
        chk("rst_rv",       32'(redirect_valid), 32'h0);
        chk("rst_rpc",      redirect_pc,         32'h0);
        chk("rst_wen",      32'(csr_wen),        32'h0);
        chk("rst_addr",     32'(csr_addr),       32'h0);
        chk("rst_wdata",    csr_wdata,           32'h0);
        rst = 1'b0;

        // Table-driven trap/mret transactions
        for (int i = 0; i < NV; i++) begin
            preload(vecs[i].mtvec, vecs[i].mepc0, vecs[i].mcause0, vecs[i].mstat0);
            chk({vecs[i].name, "_idle_addr"}, 32'(csr_addr), 32'h0);
            trap_req   = vecs[i].trap;
            mret_req   = vecs[i].mret;
            trap_pc    = vecs[i].pc;
            trap_cause = vecs[i].cause;
            @(posedge clk); #1;
            trap_req = 1'b0; mret_req = 1'b0;
            trap_pc  = 32'hBAD0BAD0; trap_cause = 32'hBAD1BAD1;
            chk({vecs[i].name, "_busy"}, 32'(busy), 32'h1);
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                if (redirect_valid) begin
                    lat = k;
                    break;
                end
                @(posedge clk); #1;
            end
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_rpc"},     redirect_pc, vecs[i].exp_redir);
            @(posedge clk); #1;
            chk({vecs[i].name, "_pulse_end"}, 32'(redirect_valid), 32'h0);
            chk({vecs[i].name, "_idle"},      32'(busy),           32'h0);
            chk({vecs[i].name, "_mepc"},      m_mepc,   vecs[i].exp_mepc);
            chk({vecs[i].name, "_mcause"},    m_mcause, vecs[i].exp_mcause);
            chk({vecs[i].name, "_mstat"},     m_mstat,  vecs[i].exp_mstat);
            chk({vecs[i].name, "_nwr"},       32'(wr_cnt), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr == 3) begin
                chk({vecs[i].name, "_wr0"},  32'(wr_addr[0]), 32'h341);
                chk({vecs[i].name, "_wr1"},  32'(wr_addr[1]), 32'h342);
                chk({vecs[i].name, "_wr2"},  32'(wr_addr[2]), 32'h300);
                chk({vecs[i].name, "_gap1"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'h1);
                chk({vecs[i].name, "_gap2"}, 32'(wr_cyc[2] - wr_cyc[1]), 32'h1);
            end else begin
                chk({vecs[i].name, "_wr0"},  32'(wr_addr[0]), 32'h300);
            end
        end

        // Reset during T_CAUSE aborts the sequence
        preload(32'h80001000, 32'h0, 32'h00000055, 32'h00000008);
        trap_req = 1'b1; trap_pc = 32'h80000100; trap_cause = 32'h0000000B;
        @(posedge clk); #1;
        trap_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_cause", 32'(csr_addr), 32'h342);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy),    32'h0);
        chk("abort_own",  32'(csr_own), 32'h0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (redirect_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_pulses", 32'(pulses), 32'h0);
        chk("abort_mepc",   m_mepc,      32'h80000100);
        chk("abort_mcause", m_mcause,    32'h00000055);
        chk("abort_mstat",  m_mstat,     32'h00000008);
        chk("abort_nwr",    32'(wr_cnt), 32'h1);

        // Second trap_req while in T_VEC is ignored
        preload(32'h80001000, 32'h0, 32'h0, 32'h00000008);
        trap_req = 1'b1; trap_pc = 32'h80000100; trap_cause = 32'h0000000B;
        @(posedge clk); #1;
        trap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("retrig_in_vec", 32'(csr_addr), 32'h305);
        trap_req = 1'b1; trap_pc = 32'h11111110; trap_cause = 32'h00000003;
        @(posedge clk); #1;
        trap_req = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (redirect_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("retrig_pulses", 32'(pulses),  32'h1);
        chk("retrig_nwr",    32'(wr_cnt),  32'h3);
        chk("retrig_mepc",   m_mepc,       32'h80000100);
        chk("retrig_rpc",    redirect_pc,  32'h80001000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
